// File: rtl/buttons_pkg.sv
// -----------------------------------------------------------------------------
// buttons_pkg
//   Shared definitions for the memory-mapped button input port: the word
//   addresses of the I/O page it shares with the LED output port, and the
//   register-select decode used by the read mux and the write strobes.
// -----------------------------------------------------------------------------
package buttons_pkg;

   // The LED output port sits at the base of the page; the button registers follow it.
   localparam logic [14:0] LED_ADDR       = 15'h7f80;
   localparam logic [14:0] BTN_STATE_ADDR = LED_ADDR + 15'd1;
   localparam logic [14:0] BTN_EVT_ADDR   = LED_ADDR + 15'd2;
   localparam logic [14:0] BTN_MASK_ADDR  = LED_ADDR + 15'd3;

   typedef enum logic [1:0] {
      SEL_NONE,
      SEL_STATE,
      SEL_EVT,
      SEL_MASK
   } reg_sel_e;

   // addr[15] is not part of the decode, so only the low 15 bits are passed in.
   function automatic reg_sel_e decode_addr(input logic [14:0] word_addr);
      reg_sel_e sel;
      case (word_addr)
         BTN_STATE_ADDR: sel = SEL_STATE;
         BTN_EVT_ADDR:   sel = SEL_EVT;
         BTN_MASK_ADDR:  sel = SEL_MASK;
         default:        sel = SEL_NONE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/buttons_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//   One button bit: 2-FF synchroniser followed by a tick-driven debouncer.
//   The debounced level only follows the synchronised input after it has
//   disagreed with it for STABLE consecutive ticks; any cycle of agreement
//   restarts the count.
// Ports
//   clk     system clock
//   rst     asynchronous active-high reset
//   tick_i  one-cycle debounce tick from the shared prescaler
//   btn_i   raw asynchronous button level (1 = pressed)
//   deb_o   debounced level
// -----------------------------------------------------------------------------
module button_debounce #(
   parameter int STABLE = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic tick_i,
   input  logic btn_i,
   output logic deb_o
);

   localparam int CW = (STABLE > 1) ? $clog2(STABLE) : 1;

   logic          meta_q;
   logic          sync_q;
   logic          deb_q;
   logic          deb_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours, which is what makes meta_q -> sync_q
   // a two-stage chain rather than a single wire.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         deb_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         meta_q <= btn_i;
         sync_q <= meta_q;
         deb_q  <= deb_d;
         cnt_q  <= cnt_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      deb_d = deb_q;
      cnt_d = cnt_q;
      if (sync_q == deb_q) begin
         cnt_d = '0;
      end else if (tick_i) begin
         if (cnt_q == CW'(STABLE - 1)) begin
            deb_d = sync_q;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   assign deb_o = deb_q;

endmodule

// File: rtl/buttons.sv
// -----------------------------------------------------------------------------
// buttons
//   Memory-mapped push-button input port on the 16-bit CPU bus. Synchronises
//   and debounces WIDTH buttons, latches press events and raises irq for
//   unmasked events. data_out is zero whenever this port is not being read,
//   so it can be OR-ed onto the shared read bus.
// Ports
//   clk       system clock
//   rst       asynchronous active-high reset
//   en        peripheral enable; qualifies rd_en / wr_en
//   rd_en     bus read strobe
//   wr_en     bus write strobe
//   addr      word address, decoded on addr[14:0]
//   data      write data
//   btn_in    raw button levels, 1 = pressed
//   data_out  registered read data (STATE / EVT / MASK), 0 when not selected
//   irq       registered |(evt & mask)
// -----------------------------------------------------------------------------
module buttons
   import buttons_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIV    = 50000,
   parameter int STABLE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             rd_en,
   input  logic             wr_en,
   input  logic [15:0]      addr,
   input  logic [15:0]      data,
   input  logic [WIDTH-1:0] btn_in,
   output logic [15:0]      data_out,
   output logic             irq
);

   localparam int PW = $clog2(DIV);

   logic [PW-1:0]    presc_q;
   logic [PW-1:0]    presc_d;
   logic             tick;
   logic [WIDTH-1:0] deb;
   logic [WIDTH-1:0] deb_prev_q;
   logic [WIDTH-1:0] evt_q;
   logic [WIDTH-1:0] evt_d;
   logic [WIDTH-1:0] evt_clr;
   logic [WIDTH-1:0] mask_q;
   logic [WIDTH-1:0] mask_d;
   logic             irq_q;
   logic             irq_d;
   logic [15:0]      dout_q;
   logic [15:0]      dout_d;
   logic             bus_rd;
   logic             bus_wr;
   reg_sel_e         sel;

   // addr[15] and write-data bits above WIDTH carry no meaning for this port.
   logic unused_bus_bits;
   assign unused_bus_bits = ^{addr[15], data};

   assign bus_rd = en & rd_en;
   assign bus_wr = en & wr_en;
   assign sel    = decode_addr(addr[14:0]);

   // Shared prescaler: one debounce tick every DIV clocks.
   assign tick    = (presc_q == PW'(DIV - 1));
   assign presc_d = tick ? '0 : presc_q + PW'(1);

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_deb
      button_debounce #(
         .STABLE (STABLE)
      ) u_debounce (
         .clk    (clk),
         .rst    (rst),
         .tick_i (tick),
         .btn_i  (btn_in[gi]),
         .deb_o  (deb[gi])
      );
   end

   always_comb begin
      evt_clr = (bus_wr && sel == SEL_EVT) ? data[WIDTH-1:0] : '0;
      // Press edges are OR-ed in after the clear so a same-cycle press survives a W1C.
      evt_d   = (evt_q & ~evt_clr) | (deb & ~deb_prev_q);
      mask_d  = (bus_wr && sel == SEL_MASK) ? data[WIDTH-1:0] : mask_q;
      irq_d   = |(evt_q & mask_q);

      // Read data comes from the current registers, i.e. before any same-cycle write.
      dout_d = '0;
      if (bus_rd) begin
         case (sel)
            SEL_STATE: dout_d[WIDTH-1:0] = deb;
            SEL_EVT:   dout_d[WIDTH-1:0] = evt_q;
            SEL_MASK:  dout_d[WIDTH-1:0] = mask_q;
            default:   dout_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q    <= '0;
         deb_prev_q <= '0;
         evt_q      <= '0;
         mask_q     <= '0;
         irq_q      <= 1'b0;
         dout_q     <= '0;
      end else begin
         presc_q    <= presc_d;
         deb_prev_q <= deb;
         evt_q      <= evt_d;
         mask_q     <= mask_d;
         irq_q      <= irq_d;
         dout_q     <= dout_d;
      end
   end

   assign data_out = dout_q;
   assign irq      = irq_q;

endmodule
